// File: rtl/controller_pkg.sv
// Shared game package: state codes, state width and the Moore output decode
// used by the game controller and the top level.
package controller_pkg;

    localparam int unsigned StateWidth = 3;

    typedef enum logic [StateWidth-1:0] {
        StInit      = 3'd0,
        StSetup     = 3'd1,
        StPlayFpga  = 3'd2,
        StPlayUser  = 3'd3,
        StCheck     = 3'd4,
        StNextRound = 3'd5,
        StResult    = 3'd6,
        StUnused    = 3'd7
    } state_e;

    typedef struct packed {
        logic r1;
        logic r2;
        logic e1;
        logic e2;
        logic e3;
        logic e4;
        logic sel;
    } ctrl_t;

    function automatic ctrl_t decode(state_e s);
        ctrl_t c;
        c = '0;
        case (s)
            StInit:      begin c.r1 = 1'b1; c.r2 = 1'b1; c.sel = 1'b1; end
            StSetup:     begin c.e1 = 1'b1; c.sel = 1'b1; end
            StPlayFpga:  begin c.e3 = 1'b1; c.r2 = 1'b1; c.sel = 1'b1; end
            StPlayUser:  begin c.e2 = 1'b1; c.sel = 1'b1; end
            StCheck:     c.sel = 1'b1;
            StNextRound: begin c.e4 = 1'b1; c.r2 = 1'b1; c.sel = 1'b1; end
            default:     c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/button_sync.sv
// Synchronizes the active-low enter button and emits a one-cycle pulse per press.
module button_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clock_50,
    input  logic reset_n,
    input  logic enter_n,
    output logic enter_p
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Reset to the released level so reset release never looks like a press.
    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], enter_n};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign enter_p = prev_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/controller.sv
// Game controller FSM: sequences setup, FPGA playback, user entry, checking and
// result display; outputs are registered and decoded from the next state.
module controller
    import controller_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clock_50,
    input  logic                  reset_n,
    input  logic                  enter_n,
    input  logic                  end_fpga,
    input  logic                  end_user,
    input  logic                  end_time,
    input  logic                  win,
    input  logic                  match,
    output logic                  r1,
    output logic                  r2,
    output logic                  e1,
    output logic                  e2,
    output logic                  e3,
    output logic                  e4,
    output logic                  sel,
    output logic [StateWidth-1:0] state
);

    logic   enter_p;
    state_e state_q;
    state_e state_d;
    ctrl_t  ctrl_q;

    button_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clock_50(clock_50),
        .reset_n (reset_n),
        .enter_n (enter_n),
        .enter_p (enter_p)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            StInit:      state_d = StSetup;
            StSetup:     if (enter_p) state_d = StPlayFpga;
            StPlayFpga:  if (end_fpga) state_d = StPlayUser;
            StPlayUser: begin
                // Timeout wins over a simultaneous end of entry.
                if (end_time) begin
                    state_d = StResult;
                end else if (end_user) begin
                    state_d = StCheck;
                end
            end
            StCheck:     state_d = (match && !win) ? StNextRound : StResult;
            StNextRound: state_d = StPlayFpga;
            StResult:    if (enter_p) state_d = StInit;
            default:     state_d = StInit;
        endcase
    end

    // Outputs are registered alongside the state so they always match state_q.
    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StInit;
            ctrl_q  <= decode(StInit);
        end else begin
            state_q <= state_d;
            ctrl_q  <= decode(state_d);
        end
    end

    assign r1    = ctrl_q.r1;
    assign r2    = ctrl_q.r2;
    assign e1    = ctrl_q.e1;
    assign e2    = ctrl_q.e2;
    assign e3    = ctrl_q.e3;
    assign e4    = ctrl_q.e4;
    assign sel   = ctrl_q.sel;
    assign state = state_q;

endmodule

// File: tb/tb_controller.sv
// Bench for the game controller: directed scenarios plus randomized play,
// every cycle compared against a behavioural game model.
module tb_controller;

    localparam int unsigned S = 2;

    logic       clock_50 = 1'b0;
    logic       reset_n  = 1'b0;
    logic       enter_n  = 1'b1;
    logic       end_fpga = 1'b0;
    logic       end_user = 1'b0;
    logic       end_time = 1'b0;
    logic       win      = 1'b0;
    logic       match    = 1'b0;
    logic       r1, r2, e1, e2, e3, e4, sel;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    int       m_state;
    logic [3:0] hist;   // sampled enter_n per edge, bit 0 newest

    always #5 clock_50 = ~clock_50;

    controller #(
        .SYNC_STAGES(S)
    ) dut (
        .clock_50(clock_50),
        .reset_n (reset_n),
        .enter_n (enter_n),
        .end_fpga(end_fpga),
        .end_user(end_user),
        .end_time(end_time),
        .win     (win),
        .match   (match),
        .r1      (r1),
        .r2      (r2),
        .e1      (e1),
        .e2      (e2),
        .e3      (e3),
        .e4      (e4),
        .sel     (sel),
        .state   (state)
    );

    // Output table {r1,r2,e1,e2,e3,e4,sel} per state code.
    function automatic logic [6:0] exp_out(int s);
        case (s)
            0:       return 7'b1100001;
            1:       return 7'b0010001;
            2:       return 7'b0100101;
            3:       return 7'b0001001;
            4:       return 7'b0000001;
            5:       return 7'b0100011;
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        hist    = 4'b1111;
    endtask

    // A press is seen by the FSM S+1 edges after the low level is first sampled.
    task automatic model_step();
        logic ep;
        ep = hist[S] & ~hist[S-1];
        case (m_state)
            0: m_state = 1;
            1: if (ep) m_state = 2;
            2: if (end_fpga) m_state = 3;
            3: if (end_time) m_state = 6; else if (end_user) m_state = 4;
            4: m_state = (match && !win) ? 5 : 6;
            5: m_state = 2;
            6: if (ep) m_state = 0;
            default: m_state = 0;
        endcase
        hist = {hist[2:0], enter_n};
    endtask

    task automatic compare();
        check("state", int'(state), m_state);
        check("outputs", int'({r1, r2, e1, e2, e3, e4, sel}), int'(exp_out(m_state)));
    endtask

    task automatic tick();
        @(posedge clock_50);
        model_step();
        @(negedge clock_50);
        compare();
    endtask

    // Called just after a falling edge; reset pulse fits inside the low phase.
    task automatic mid_reset();
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_state", int'(state), 0);
        check("async_rst_e2", int'(e2), 0);
        check("async_rst_outs", int'({r1, r2, e1, e2, e3, e4, sel}), 7'b1100001);
        model_reset();
        #1 reset_n = 1'b1;
    endtask

    task automatic press_until(input int target, input string name);
        int n;
        n = 0;
        enter_n = 1'b0;
        while (int'(state) != target && n < 10) begin
            tick();
            n++;
        end
        check(name, n, S + 1);
        enter_n = 1'b1;
    endtask

    initial begin
        int n;
        model_reset();
        #12;
        check("reset_state", int'(state), 0);
        check("reset_outs", int'({r1, r2, e1, e2, e3, e4, sel}), 7'b1100001);
        @(negedge clock_50);
        reset_n = 1'b1;
        check("init_after_release", int'(state), 0);
        tick();
        check("setup_state", int'(state), 1);
        check("setup_e1", int'(e1), 1);
        check("setup_sel", int'(sel), 1);
        repeat (5) tick();
        check("no_spurious_press", int'(state), 1);

        // Long press: one pulse only.
        n = 0;
        enter_n = 1'b0;
        while (int'(state) != 2 && n < 10) begin
            tick();
            n++;
        end
        check("enter_latency", n, S + 1);
        repeat (50 - n) tick();
        enter_n = 1'b1;
        repeat (3) tick();
        check("held_one_pulse", int'(state), 2);

        end_fpga = 1'b1; tick(); end_fpga = 1'b0;
        check("play_user", int'(state), 3);
        end_user = 1'b1; end_time = 1'b1; tick();
        end_user = 1'b0; end_time = 1'b0;
        check("timeout_priority", int'(state), 6);
        check("result_sel", int'(sel), 0);
        tick();
        check("result_hold", int'(state), 6);

        press_until(0, "result_press_latency");
        check("init_r1r2", int'({r1, r2}), 2'b11);
        tick();
        check("init_to_setup", int'(state), 1);

        // Matched, non-final round.
        press_until(2, "setup_press_latency");
        end_fpga = 1'b1; tick(); end_fpga = 1'b0;
        end_user = 1'b1; tick(); end_user = 1'b0;
        check("check_state", int'(state), 4);
        match = 1'b1; win = 1'b0; tick();
        check("next_round", int'(state), 5);
        check("next_round_e4_r2", int'({e4, r2}), 2'b11);
        tick();
        check("back_to_fpga", int'(state), 2);
        check("fpga_e3", int'(e3), 1);
        check("e4_single", int'(e4), 0);

        // Final round won.
        end_fpga = 1'b1; tick(); end_fpga = 1'b0;
        end_user = 1'b1; tick(); end_user = 1'b0;
        win = 1'b1; tick();
        match = 1'b0; win = 1'b0;
        check("win_result", int'(state), 6);
        press_until(0, "win_press_latency");
        tick();
        check("win_to_setup", int'(state), 1);

        // Reset mid-game in PLAY_USER.
        press_until(2, "pre_reset_press");
        end_fpga = 1'b1; tick(); end_fpga = 1'b0;
        check("pre_reset_play_user", int'(state), 3);
        mid_reset();
        tick();
        check("post_reset_setup", int'(state), 1);

        // Randomized play against the model.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 5) == 0) enter_n = ~enter_n;
            end_fpga = ($urandom_range(0, 3) == 0);
            end_user = ($urandom_range(0, 3) == 0);
            end_time = ($urandom_range(0, 7) == 0);
            match    = ($urandom_range(0, 3) != 0);
            win      = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 399) == 0) mid_reset();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
